game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Frame-rate game controller for the lane runner. It replaces the hard-wired single-clock-edge game FSM and the fixed three spawn instances.
- Runs entirely in the clk domain. Advances only on a one-cycle frame_tick strobe, which is a synchronised VSYNC edge.
- Handles N parametrised lanes, discrete player lane changes, coin/obstacle spawning, collision, score, pause and game-over.
- Its outputs drive the layer offsets (logo, head, object replicas).

Parameters:
LANES, 3, number of lanes/object slots (1..6)
WIDTH, 12, signed offset width
COUNTDOWN, 5, idle ticks before logo fade
FADE_STEP, 30, logo voffset increment per tick
FADE_END, 640, logo fade complete threshold
ENTER_START, 180, player voffset at start of entry
ENTER_END, 50, player voffset entry threshold
ENTER_STEP, 20, player voffset decrement per tick
LANE_PITCH, 100, horizontal spacing between lanes
VSRC, -140, object spawn voffset
VDST, 220, object despawn limit
SPAWN_STEP, 32, object voffset increment per tick
HIT_LO, 150, collision window low (inclusive)
HIT_HI, 210, collision window high (inclusive)

Ports:
clk  in  1  system clock (100 MHz)
CPU_RESETN  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame
btn_left  in  1  synchronised level
btn_right  in  1  synchronised level
pause  in  1  synchronised level
random  in  20  LFSR value
state  out  3  RESET=0 COUNT=1 FADE=2 ENTER=3 PLAY=4 PAUSE=5 OVER=6
logo_voffset  out  WIDTH  logo layer voffset
player_hoffset  out  WIDTH  signed, (lane - LANES/2)*LANE_PITCH
player_voffset  out  WIDTH  head layer voffset
obj_hoffset  out  LANES*WIDTH  slot k = (k - LANES/2)*LANE_PITCH, constant
obj_voffset  out  LANES*WIDTH  per-slot voffset
obj_active  out  LANES  slot visible
obj_kind  out  LANES  0=coin 1=obstacle
score  out  16  coins collected

Behaviour:
- Async reset values: state=RESET, logo=0, player_voffset=ENTER_START, lane=LANES/2, score=0, all obj_active=0, obj_voffset=VSRC, obj_kind=0, button history=0.
- All outputs are registered. Nothing changes on cycles without frame_tick. Results appear the cycle after the tick.
- Button edge = level at this tick AND NOT level at previous tick. History updates on every tick, in every state.
- RESET: on tick, reload all reset values except state and history, then go to COUNT with countdown=COUNTDOWN.
- COUNT: on tick, if countdown>0 decrement it; otherwise go to FADE.
- FADE: on tick, if logo<FADE_END add FADE_STEP; otherwise go to ENTER.
- ENTER: on tick, if player_voffset>ENTER_END subtract ENTER_STEP; otherwise go to PLAY.
- PLAY: on tick with pause=1, go to PAUSE and freeze. Otherwise, in order, all using start-of-tick values:
  1. Collision, per active slot k with k==lane and HIT_LO<=voffset<=HIT_HI (signed):
     - coin: score+1, saturating at 0xFFFF; slot cleared.
     - obstacle: go to OVER; no other update this tick.
  2. Move, per active non-collided slot: voffset+=SPAWN_STEP. If the result is >VDST (signed), clear the slot and set voffset=VSRC.
  3. Spawn, per slot inactive at tick start: if random[3k+2:3k]==3'b111, set active, voffset=VSRC, kind=random[19].
  4. Lane:
     - left edge only: lane-1, saturating at 0.
     - right edge only: lane+1, saturating at LANES-1.
     - both edges: no change.
- PAUSE: everything frozen. On tick with pause=0, go to PLAY; motion resumes on the following tick.
- OVER: everything frozen, score held. On tick, any button edge goes to RESET, which clears score on its next tick.
- A slot cleared this tick cannot respawn until the next tick.
- Arithmetic is WIDTH-bit two's complement; comparisons are signed.
- Reset mid-game returns to RESET immediately, asynchronously.

Test Plan:
- Reset release, frame_tick every 10 cycles, buttons idle: state RESET→COUNT on tick 1, FADE on tick 7, ENTER on tick 30 (logo=660), PLAY on tick 38 (player_voffset=40).
- In PLAY, random[2:0]=111 for one tick with random[19]=0, lane=1, then random=0: slot0 voffset=-140, then -108… After 10 more ticks it reaches 180 in slot 0, but lane=1 so no hit; it despawns after 212 (next value 244>220).
- Same spawn in slot 1 (random[5:3]=111): when voffset=180 at tick start, score 0→1 and slot1 clears; with random[19]=1 instead, state→OVER and score holds.
- Lane control: press left twice across ticks → lane 0, player_hoffset=-100; press left again → still 0. Press both in one tick → unchanged.
- Pause: assert pause mid-flight with voffset=52 → held at 52 for 5 ticks. Deassert → 84 one tick later.
- In OVER, press right → RESET, then COUNT, score=0. Assert CPU_RESETN low mid-FADE → state=0 and logo=0 without a clk edge.

Source files
------------

// File: rtl/game_sequencer.sv
// Frame-rate lane-runner controller: intro sequence, lane changes, object spawn/motion,
// collision scoring, pause and game-over, all stepping once per frame_tick.
module game_sequencer #(
  parameter int LANES       = 3,
  parameter int WIDTH       = 12,
  parameter int COUNTDOWN   = 5,
  parameter int FADE_STEP   = 30,
  parameter int FADE_END    = 640,
  parameter int ENTER_START = 180,
  parameter int ENTER_END   = 50,
  parameter int ENTER_STEP  = 20,
  parameter int LANE_PITCH  = 100,
  parameter int VSRC        = -140,
  parameter int VDST        = 220,
  parameter int SPAWN_STEP  = 32,
  parameter int HIT_LO      = 150,
  parameter int HIT_HI      = 210
) (
  input  logic                     clk,
  input  logic                     CPU_RESETN,
  input  logic                     frame_tick,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     pause,
  input  logic [19:0]              random,
  output logic [2:0]               state,
  output logic signed [WIDTH-1:0]  logo_voffset,
  output logic signed [WIDTH-1:0]  player_hoffset,
  output logic signed [WIDTH-1:0]  player_voffset,
  output logic [LANES*WIDTH-1:0]   obj_hoffset,
  output logic [LANES*WIDTH-1:0]   obj_voffset,
  output logic [LANES-1:0]         obj_active,
  output logic [LANES-1:0]         obj_kind,
  output logic [15:0]              score
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (COUNTDOWN > 0) ? $clog2(COUNTDOWN + 1) : 1;

  typedef logic signed [WIDTH-1:0] off_t;
  typedef enum logic [2:0] {
    ST_RESET = 3'd0, ST_COUNT = 3'd1, ST_FADE = 3'd2, ST_ENTER = 3'd3,
    ST_PLAY  = 3'd4, ST_PAUSE = 3'd5, ST_OVER = 3'd6
  } state_t;

  localparam off_t VSRC_W        = off_t'(VSRC);
  localparam off_t VDST_W        = off_t'(VDST);
  localparam off_t HIT_LO_W      = off_t'(HIT_LO);
  localparam off_t HIT_HI_W      = off_t'(HIT_HI);
  localparam off_t FADE_END_W    = off_t'(FADE_END);
  localparam off_t FADE_STEP_W   = off_t'(FADE_STEP);
  localparam off_t ENTER_START_W = off_t'(ENTER_START);
  localparam off_t ENTER_END_W   = off_t'(ENTER_END);
  localparam off_t ENTER_STEP_W  = off_t'(ENTER_STEP);
  localparam logic [LW-1:0] LANE_MID  = LW'(LANES / 2);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  function automatic off_t lane_offset(input logic [LW-1:0] l);
    return off_t'((int'(l) - LANES / 2) * LANE_PITCH);
  endfunction

  state_t                      state_reg;
  off_t                        logo_reg;
  off_t                        pv_reg;
  off_t                        ph_reg;
  logic [LW-1:0]               lane_reg;
  logic [LW-1:0]               lane_next;
  logic [15:0]                 score_reg;
  logic [LANES-1:0]            act_reg;
  logic [LANES-1:0]            kind_reg;
  logic [LANES-1:0][WIDTH-1:0] vo_reg;
  logic [LANES-1:0][WIDTH-1:0] moved;
  logic [CW-1:0]               cd_reg;
  logic                        left_prev_reg;
  logic                        right_prev_reg;
  logic [LANES-1:0]            hit;
  logic [LANES-1:0]            spawn;
  logic [LANES-1:0]            coin_hit;
  logic [LANES-1:0]            obst_hit;
  logic                        left_edge;
  logic                        right_edge;
  logic                        unused_random;

  assign left_edge     = btn_left & ~left_prev_reg;
  assign right_edge    = btn_right & ~right_prev_reg;
  assign coin_hit      = hit & ~kind_reg;
  assign obst_hit      = hit & kind_reg;
  assign unused_random = ^random;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_slot
    assign hit[gi] = act_reg[gi] && (lane_reg == LW'(gi)) &&
                     ($signed(vo_reg[gi]) >= HIT_LO_W) && ($signed(vo_reg[gi]) <= HIT_HI_W);
    assign moved[gi] = vo_reg[gi] + WIDTH'(SPAWN_STEP);
    assign spawn[gi] = !act_reg[gi] && (random[3*gi +: 3] == 3'b111);
    assign obj_hoffset[gi*WIDTH +: WIDTH] = WIDTH'((gi - LANES / 2) * LANE_PITCH);
  end

  // Simultaneous edges cancel; otherwise step one lane with saturation.
  always_comb begin
    lane_next = lane_reg;
    if (left_edge && !right_edge && lane_reg != '0)
      lane_next = lane_reg - LW'(1);
    else if (right_edge && !left_edge && lane_reg != LANE_LAST)
      lane_next = lane_reg + LW'(1);
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_reg      <= ST_RESET;
      logo_reg       <= '0;
      pv_reg         <= ENTER_START_W;
      lane_reg       <= LANE_MID;
      ph_reg         <= lane_offset(LANE_MID);
      score_reg      <= '0;
      act_reg        <= '0;
      kind_reg       <= '0;
      vo_reg         <= {LANES{VSRC_W}};
      cd_reg         <= '0;
      left_prev_reg  <= 1'b0;
      right_prev_reg <= 1'b0;
    end else if (frame_tick) begin
      left_prev_reg  <= btn_left;
      right_prev_reg <= btn_right;
      case (state_reg)
        ST_RESET: begin
          logo_reg  <= '0;
          pv_reg    <= ENTER_START_W;
          lane_reg  <= LANE_MID;
          ph_reg    <= lane_offset(LANE_MID);
          score_reg <= '0;
          act_reg   <= '0;
          kind_reg  <= '0;
          vo_reg    <= {LANES{VSRC_W}};
          cd_reg    <= CW'(COUNTDOWN);
          state_reg <= ST_COUNT;
        end
        ST_COUNT: begin
          if (cd_reg != '0) cd_reg <= cd_reg - CW'(1);
          else              state_reg <= ST_FADE;
        end
        ST_FADE: begin
          if (logo_reg < FADE_END_W) logo_reg <= logo_reg + FADE_STEP_W;
          else                       state_reg <= ST_ENTER;
        end
        ST_ENTER: begin
          if (pv_reg > ENTER_END_W) pv_reg <= pv_reg - ENTER_STEP_W;
          else                      state_reg <= ST_PLAY;
        end
        ST_PLAY: begin
          if (pause) begin
            state_reg <= ST_PAUSE;
          end else if (|obst_hit) begin
            state_reg <= ST_OVER;
          end else begin
            if ((|coin_hit) && (score_reg != 16'hFFFF)) score_reg <= score_reg + 16'd1;
            // Spawn only considers slots idle at tick start, so a slot freed now waits a tick.
            for (int k = 0; k < LANES; k++) begin
              if (coin_hit[k]) begin
                act_reg[k] <= 1'b0;
                vo_reg[k]  <= VSRC_W;
              end else if (act_reg[k]) begin
                if ($signed(moved[k]) > VDST_W) begin
                  act_reg[k] <= 1'b0;
                  vo_reg[k]  <= VSRC_W;
                end else begin
                  vo_reg[k] <= moved[k];
                end
              end else if (spawn[k]) begin
                act_reg[k]  <= 1'b1;
                vo_reg[k]   <= VSRC_W;
                kind_reg[k] <= random[19];
              end
            end
            lane_reg <= lane_next;
            ph_reg   <= lane_offset(lane_next);
          end
        end
        ST_PAUSE: begin
          if (!pause) state_reg <= ST_PLAY;
        end
        ST_OVER: begin
          if (left_edge || right_edge) state_reg <= ST_RESET;
        end
        default: state_reg <= ST_RESET;
      endcase
    end
  end

  assign state          = state_reg;
  assign logo_voffset   = logo_reg;
  assign player_hoffset = ph_reg;
  assign player_voffset = pv_reg;
  assign obj_voffset    = vo_reg;
  assign obj_active     = act_reg;
  assign obj_kind       = kind_reg;
  assign score          = score_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: expectations are queued as each frame is driven
// and compared against the outputs once that frame's results are registered.
module tb_game_sequencer;

  localparam int SEL_STATE = 0, SEL_LOGO = 1, SEL_PH = 2, SEL_PV = 3, SEL_SCORE = 4;
  localparam int SEL_V0 = 5, SEL_V1 = 6, SEL_ACT = 7, SEL_KIND = 8, SEL_H0 = 9, SEL_H2 = 10;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        btn_left;
  logic        btn_right;
  logic        pause;
  logic [19:0] random;
  logic [2:0]  state;
  logic signed [11:0] logo_voffset, player_hoffset, player_voffset;
  logic [35:0] obj_hoffset, obj_voffset;
  logic [2:0]  obj_active, obj_kind;
  logic [15:0] score;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk            (clk),
    .CPU_RESETN     (rst_n),
    .frame_tick     (frame_tick),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .pause          (pause),
    .random         (random),
    .state          (state),
    .logo_voffset   (logo_voffset),
    .player_hoffset (player_hoffset),
    .player_voffset (player_voffset),
    .obj_hoffset    (obj_hoffset),
    .obj_voffset    (obj_voffset),
    .obj_active     (obj_active),
    .obj_kind       (obj_kind),
    .score          (score)
  );

  function automatic logic signed [31:0] observe(input int sel);
    logic [35:0] v;
    logic [35:0] h;
    v = obj_voffset;
    h = obj_hoffset;
    case (sel)
      SEL_STATE: return 32'(state);
      SEL_LOGO:  return 32'(logo_voffset);
      SEL_PH:    return 32'(player_hoffset);
      SEL_PV:    return 32'(player_voffset);
      SEL_SCORE: return 32'(score);
      SEL_V0:    return 32'($signed(v[11:0]));
      SEL_V1:    return 32'($signed(v[23:12]));
      SEL_ACT:   return 32'(obj_active);
      SEL_KIND:  return 32'(obj_kind);
      SEL_H0:    return 32'($signed(h[11:0]));
      SEL_H2:    return 32'($signed(h[35:24]));
      default:   return 32'hDEAD;
    endcase
  endfunction

  task automatic push(input string n, input int sel, input int v);
    exp_t x;
    x.name = n;
    x.sel  = sel;
    x.exp  = v;
    sb.push_back(x);
  endtask

  // Ten-cycle frame period; returns on the negedge after the tick was latched.
  task automatic tick();
    repeat (9) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    push("rst_state", SEL_STATE, 0); push("rst_logo", SEL_LOGO, 0);
    push("rst_pv", SEL_PV, 180);     push("rst_ph", SEL_PH, 0);
    push("rst_score", SEL_SCORE, 0); push("rst_act", SEL_ACT, 0);
    push("rst_v0", SEL_V0, -140);    push("rst_kind", SEL_KIND, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observe(e.sel) !== 32'(e.exp)) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_intro();
    for (int t = 1; t <= 38; t++) begin
      push($sformatf("intro_state_t%0d", t), SEL_STATE, (t <= 6) ? 1 : (t <= 29) ? 2 : (t <= 37) ? 3 : 4);
      push($sformatf("intro_logo_t%0d", t), SEL_LOGO, (t <= 7) ? 0 : (t <= 29) ? 30 * (t - 7) : 660);
      push($sformatf("intro_pv_t%0d", t), SEL_PV, (t <= 30) ? 180 : (t <= 37) ? 180 - 20 * (t - 30) : 40);
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  // Slot 0 is in lane 0 while the player sits in lane 1, so it falls through and despawns.
  task automatic test_spawn_miss();
    for (int n = 0; n <= 12; n++) begin
      random = (n == 0) ? 20'h00007 : 20'h0;
      push($sformatf("miss_v0_n%0d", n), SEL_V0, (n <= 11) ? -140 + 32 * n : -140);
      push($sformatf("miss_act_n%0d", n), SEL_ACT, (n <= 11) ? 1 : 0);
      push($sformatf("miss_state_n%0d", n), SEL_STATE, 4);
      push($sformatf("miss_score_n%0d", n), SEL_SCORE, 0);
      if (n == 0) push("miss_kind", SEL_KIND, 0);
      tick();
      random = 20'h0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  task automatic test_coin();
    for (int n = 0; n <= 11; n++) begin
      random = (n == 0) ? 20'h00038 : 20'h0;
      if (n <= 10) push($sformatf("coin_v1_n%0d", n), SEL_V1, -140 + 32 * n);
      push($sformatf("coin_act_n%0d", n), SEL_ACT, (n <= 10) ? 2 : 0);
      push($sformatf("coin_score_n%0d", n), SEL_SCORE, (n <= 10) ? 0 : 1);
      push($sformatf("coin_state_n%0d", n), SEL_STATE, 4);
      tick();
      random = 20'h0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  task automatic test_obstacle();
    for (int n = 0; n <= 13; n++) begin
      random = (n == 0) ? 20'h80038 : 20'h0;
      push($sformatf("obst_v1_n%0d", n), SEL_V1, (n <= 10) ? -140 + 32 * n : 180);
      push($sformatf("obst_act_n%0d", n), SEL_ACT, 2);
      push($sformatf("obst_kind_n%0d", n), SEL_KIND, 2);
      push($sformatf("obst_state_n%0d", n), SEL_STATE, (n <= 10) ? 4 : 6);
      push($sformatf("obst_score_n%0d", n), SEL_SCORE, 1);
      tick();
      random = 20'h0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
  endtask

  task automatic test_over_exit();
    for (int n = 0; n < 3; n++) begin
      btn_right = (n < 2);
      if (n == 0) begin
        push("over_exit_state", SEL_STATE, 0); push("over_exit_score", SEL_SCORE, 1);
        tick();
      end else if (n == 1) begin
        push("restart_state", SEL_STATE, 1); push("restart_score", SEL_SCORE, 0);
        push("restart_pv", SEL_PV, 180);     push("restart_act", SEL_ACT, 0);
        tick();
      end else begin
        push("replay_state", SEL_STATE, 4);  push("replay_pv", SEL_PV, 40);
        push("replay_logo", SEL_LOGO, 660);  push("replay_ph", SEL_PH, 0);
        repeat (37) tick();
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
    btn_right = 1'b0;
  endtask

  task automatic test_lanes();
    int tl[14] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int tr[14] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int th[14] = '{-100, -100, -100, -100, 0, 0, 0, 100, 100, 100, 100, 100, 100, 100};
    push("obj_h0", SEL_H0, -100);
    push("obj_h2", SEL_H2, 100);
    for (int s = 0; s < 14; s++) begin
      if (s == 13) begin
        // Button held only between frames must leave no trace.
        @(negedge clk) btn_left = 1'b1;
        repeat (3) @(negedge clk);
        btn_left = 1'b0;
      end else begin
        btn_left  = tl[s][0];
        btn_right = tr[s][0];
      end
      push($sformatf("lane_ph_s%0d", s), SEL_PH, th[s]);
      push($sformatf("lane_state_s%0d", s), SEL_STATE, 4);
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
    btn_left  = 1'b0;
    btn_right = 1'b0;
  endtask

  task automatic test_pause();
    int ps[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    int sv[14] = '{-140, -108, -76, -44, -12, 20, 52, 52, 52, 52, 52, 52, 52, 84};
    for (int s = 0; s < 14; s++) begin
      random = (s == 0) ? 20'h00007 : 20'h0;
      pause  = ps[s][0];
      push($sformatf("pause_v0_s%0d", s), SEL_V0, sv[s]);
      push($sformatf("pause_state_s%0d", s), SEL_STATE, (ps[s] != 0) ? 5 : 4);
      tick();
      random = 20'h0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push("fade_state", SEL_STATE, 2);
        push("fade_logo", SEL_LOGO, 240);
        repeat (15) tick();
      end else begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        push("async_state", SEL_STATE, 0);
        push("async_logo", SEL_LOGO, 0);
        push("async_pv", SEL_PV, 180);
        push("async_act", SEL_ACT, 0);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observe(e.sel) !== 32'(e.exp)) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, observe(e.sel), e.exp);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    frame_tick = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    pause      = 1'b0;
    random     = 20'h0;
    test_reset();
    test_intro();
    test_spawn_miss();
    test_coin();
    test_obstacle();
    test_over_exit();
    test_lanes();
    test_pause();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
